// File: rtl/grid_mem_arbiter_pkg.sv
// grid_mem_arbiter_pkg
// Shared definitions for the grid memory arbiter: arbitration FSM state
// type, default grid memory geometry and the requester id assignments.
package grid_mem_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int GRID_ADDR_W = 12;
    localparam int GRID_DATA_W = 32;

    localparam int REQ_SCATTER = 0;
    localparam int REQ_SOLVE   = 1;
    localparam int REQ_GATHER  = 2;

endpackage

// File: rtl/grid_mem_arbiter_rsp_pipe.sv
// arb_rsp_pipe
// READ_LAT-deep shift register of {valid, requester id} that tracks reads
// in flight to the grid memory, so read data can be steered back to the
// requester that issued it.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valids)
//   in_vld, in_id   read granted this cycle and its requester id
//   out_vld, out_id read data from memory belongs to out_id this cycle
//   empty           no read in flight
module arb_rsp_pipe #(
    parameter int READ_LAT = 2,
    parameter int ID_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [ID_W-1:0] in_id,
    output logic            out_vld,
    output logic [ID_W-1:0] out_id,
    output logic            empty
);

    logic [READ_LAT-1:0] vld_p;
    logic [ID_W-1:0]     id_p [READ_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            for (int s = 1; s < READ_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    // Ids only matter alongside a set valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        id_p[0] <= in_id;
        for (int s = 1; s < READ_LAT; s++) begin
            id_p[s] <= id_p[s-1];
        end
    end

    assign out_vld = vld_p[READ_LAT-1];
    assign out_id  = id_p[READ_LAT-1];
    assign empty   = ~|vld_p;

endmodule

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter
// Round-robin arbiter sharing the single-port grid BRAM between scatter,
// field solver and field gather. One access per cycle; a requester may
// lock the grant across a read-modify-write pair. Read data is routed back
// to the issuing requester READ_LAT cycles after its grant.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   phase_en                 per-requester enable from the step controller
//   req_valid/we/lock        request, write select, hold grant afterwards
//   req_addr, req_wdata      packed per-requester address / write data
//   req_ready                one-hot grant (access taken on valid&ready)
//   rsp_valid, rsp_data      read response strobe per requester, shared data
//   mem_en/we/addr/wdata     memory strobes and muxed winner access
//   mem_rdata                memory read data, READ_LAT after a read strobe
//   idle                     no grant this cycle and no read in flight
// Optional build macro GRID_ARB_STATS_EN adds stat_clr, stat_grants and
// stat_stalls (saturating 32-bit per-requester counters).
module grid_mem_arbiter
    import grid_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = GRID_ADDR_W,
    parameter int DATA_W   = GRID_DATA_W,
    parameter int READ_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        phase_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      idle
`ifdef GRID_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_REQ*32-1:0]     stat_grants,
    output logic [NUM_REQ*32-1:0]     stat_stalls
`endif
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state_q, state_n;
    logic [ID_W-1:0]     ptr_q, ptr_n, owner_q, owner_n, win, cand;
    logic [NUM_REQ-1:0]  elig, ready;
    logic                grant, hold_q, block;
    logic                pipe_vld, pipe_empty;
    logic [ID_W-1:0]     pipe_id;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    assign elig = req_valid & phase_en;

    // Grants are suppressed in the reset cycle and the one after it, so
    // every output is quiet across the reset boundary.
    assign block = rst | hold_q;

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        owner_n = owner_q;
        ready   = '0;
        win     = '0;
        cand    = '0;
        grant   = 1'b0;
        if (!block) begin
            case (state_q)
                ARB: begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                        if (!grant && elig[cand]) begin
                            grant = 1'b1;
                            win   = cand;
                        end
                    end
                    if (grant) begin
                        ready[win] = 1'b1;
                        ptr_n      = next_id(win);
                        if (req_lock[win]) begin
                            state_n = LOCKED;
                            owner_n = win;
                        end
                    end
                end
                LOCKED: begin
                    // Losing the phase enable forcibly releases the lock;
                    // nobody is granted in that release cycle.
                    if (!phase_en[owner_q]) begin
                        state_n = ARB;
                        ptr_n   = next_id(owner_q);
                    end else if (elig[owner_q]) begin
                        grant          = 1'b1;
                        win            = owner_q;
                        ready[owner_q] = 1'b1;
                        if (!req_lock[owner_q]) begin
                            state_n = ARB;
                            ptr_n   = next_id(owner_q);
                        end
                    end
                end
                default: state_n = ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            owner_q <= owner_n;
            hold_q  <= 1'b0;
        end
    end

    assign req_ready = ready;
    assign mem_en    = grant;
    assign mem_we    = grant & req_we[win];
    assign mem_addr  = grant ? req_addr[int'(win)*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata = grant ? req_wdata[int'(win)*DATA_W +: DATA_W] : '0;

    arb_rsp_pipe #(
        .READ_LAT (READ_LAT),
        .ID_W     (ID_W)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (grant & ~req_we[win]),
        .in_id   (win),
        .out_vld (pipe_vld),
        .out_id  (pipe_id),
        .empty   (pipe_empty)
    );

    // Reads still in flight when reset arrives are dropped, including one
    // that would have completed in the reset cycle itself.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (pipe_vld && !rst) begin
            rsp_valid[pipe_id] = 1'b1;
            rsp_data           = mem_rdata;
        end
    end

    assign idle = rst | (~grant & pipe_empty);

`ifdef GRID_ARB_STATS_EN
    logic [31:0] gcnt [NUM_REQ];
    logic [31:0] scnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt[i] <= '0;
                scnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && ready[i] && gcnt[i] != '1) gcnt[i] <= gcnt[i] + 1'b1;
                if (elig[i] && !ready[i] && scnt[i] != '1)     scnt[i] <= scnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        stat_stalls = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*32 +: 32] = gcnt[i];
            stat_stalls[i*32 +: 32] = scnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb_grid_mem_arbiter
// Table-driven bench for grid_mem_arbiter with a BRAM model behind the
// memory port and a scoreboard queue of expected read responses.
module tb_grid_mem_arbiter;

    localparam int NR  = 3;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   phase_en = '0, req_valid = '0, req_we = '0, req_lock = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]   req_ready, rsp_valid;
    logic [DW-1:0]   rsp_data, mem_wdata, mem_rdata;
    logic            mem_en, mem_we, idle;
    logic [AW-1:0]   mem_addr;

    grid_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .phase_en  (phase_en),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Grid BRAM behind the arbiter: two-cycle registered read.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    logic [DW-1:0] rd0, rd1;
    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
        rd0 <= bram[mem_addr];
        rd1 <= rd0;
    end
    assign mem_rdata = rd1;

    typedef struct {
        logic          r;
        logic [2:0]    pen, val, we, lock, exp_rdy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } vec_t;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t sb [$];
    vec_t vecs [$];
    int   compared = 0;
    int   mismatched = 0;
    int   stepno = 0;

    function automatic vec_t mk(logic r, logic [2:0] pen, logic [2:0] val, logic [2:0] we,
                                logic [2:0] lock, logic [2:0] exp_rdy,
                                logic [AW-1:0] addr, logic [DW-1:0] wd);
        vec_t v;
        v.r = r; v.pen = pen; v.val = val; v.we = we; v.lock = lock;
        v.exp_rdy = exp_rdy; v.addr = addr; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s step %0d: got %h, want %h", nm, stepno, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        int            w;
        logic          exp_idle;
        logic [NR-1:0] exp_rv;
        rsp_t          e;
        @(negedge clk);
        rst       = v.r;
        phase_en  = v.pen;
        req_valid = v.val;
        req_we    = v.we;
        req_lock  = v.lock;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = v.addr + AW'(i);
            req_wdata[i*DW +: DW] = v.wd + DW'(i);
        end
        if (v.r) sb.delete();
        exp_idle = v.r || (v.exp_rdy == '0 && sb.size() == 0);
        #1;
        chk("req_ready", DW'(req_ready), DW'(v.exp_rdy));
        chk("mem_en", DW'(mem_en), DW'(|v.exp_rdy));
        chk("idle", DW'(idle), DW'(exp_idle));
        w = 0;
        for (int i = 0; i < NR; i++) if (v.exp_rdy[i]) w = i;
        if (v.exp_rdy != '0) begin
            chk("mem_we", DW'(mem_we), DW'(v.we[w]));
            chk("mem_addr", DW'(mem_addr), DW'(v.addr + AW'(w)));
            if (v.we[w]) chk("mem_wdata", mem_wdata, v.wd + DW'(w));
        end
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp_rv[e.id] = 1'b1;
            chk("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
            chk("rsp_data", rsp_data, e.data);
        end else begin
            chk("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
        end
        if (v.exp_rdy != '0) begin
            if (v.we[w]) begin
                model_mem[v.addr + AW'(w)] = v.wd + DW'(w);
            end else begin
                e.id   = 2'(w);
                e.data = model_mem[v.addr + AW'(w)];
                e.due  = cyc + LAT;
                sb.push_back(e);
            end
        end
        stepno++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            bram[a]      = 32'hA000_0000 | DW'(a);
            model_mem[a] = 32'hA000_0000 | DW'(a);
        end

        // reset cycle, then the quiet cycle after reset even with requests
        vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 12'h000, 32'h0));
        vecs.push_back(mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 12'h100, 32'h0));
        // all three reading every cycle: round robin 0,1,2 x3
        for (int k = 0; k < 9; k++)
            vecs.push_back(mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b001 << (k % 3),
                              12'h100 + AW'(k * 4), 32'h0));
        // write then read-after-write on the same address
        vecs.push_back(mk(0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 12'h020, 32'hDEADBEEF));
        vecs.push_back(mk(0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 12'h020, 32'h0));
        // only gather enabled
        vecs.push_back(mk(0, 3'b100, 3'b111, 3'b000, 3'b000, 3'b100, 12'h200, 32'h0));
        vecs.push_back(mk(0, 3'b100, 3'b111, 3'b000, 3'b000, 3'b100, 12'h204, 32'h0));
        // scatter RMW with gather requesting throughout
        vecs.push_back(mk(0, 3'b101, 3'b101, 3'b000, 3'b001, 3'b001, 12'h010, 32'h0));
        vecs.push_back(mk(0, 3'b101, 3'b100, 3'b000, 3'b000, 3'b000, 12'h010, 32'h0));
        vecs.push_back(mk(0, 3'b101, 3'b101, 3'b001, 3'b000, 3'b001, 12'h010, 32'h0000_1234));
        vecs.push_back(mk(0, 3'b101, 3'b101, 3'b000, 3'b000, 3'b100, 12'h010, 32'h0));
        // solver lock, then its phase enable drops
        vecs.push_back(mk(0, 3'b111, 3'b010, 3'b000, 3'b010, 3'b010, 12'h300, 32'h0));
        vecs.push_back(mk(0, 3'b101, 3'b111, 3'b000, 3'b000, 3'b000, 12'h304, 32'h0));
        vecs.push_back(mk(0, 3'b101, 3'b101, 3'b000, 3'b000, 3'b100, 12'h308, 32'h0));
        vecs.push_back(mk(0, 3'b101, 3'b101, 3'b000, 3'b000, 3'b001, 12'h30C, 32'h0));
        vecs.push_back(mk(0, 3'b101, 3'b101, 3'b000, 3'b000, 3'b100, 12'h310, 32'h0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // reset one cycle after a read grant: response dropped, pointer back to 0
        step(mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b001, 12'h400, 32'h0));
        step(mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b010, 12'h404, 32'h0));
        step(mk(1, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 12'h408, 32'h0));
        step(mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 12'h40C, 32'h0));
        step(mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b001, 12'h410, 32'h0));
        for (int i = 0; i < 4; i++)
            step(mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 12'h000, 32'h0));
        chk("drain", DW'(sb.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/grid_mem_arbiter.md
Name: grid_mem_arbiter

Overview:
- Shares the single-port grid memory between three requesters:
  - 0 = scatter (charge accumulate, read-modify-write)
  - 1 = field solver (read/write)
  - 2 = pusher field gather (read-only)
- Sits between the step controller and the grid BRAM.
- The controller enables requesters per phase through phase_en; the arbiter grants one access per cycle, round-robin.
- Routes read data back to the issuing requester after a fixed latency.

Parameters:
- NUM_REQ, 3, number of requesters.
- ADDR_W, 12, grid memory address width.
- DATA_W, 32, grid word width (fixed-point).
- READ_LAT, 2, memory read latency in cycles, 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- phase_en  in  NUM_REQ  per-requester enable from the controller.
- req_valid  in  NUM_REQ  access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  hold the grant after this access (RMW pairing).
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot grant; the access is taken when valid&ready.
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_data  out  DATA_W  shared read data bus.
- mem_en, mem_we  out  1, 1  memory strobes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after mem_en with !mem_we.
- idle  out  1  no grant this cycle and no read in flight.

Behaviour:
- Eligible(i) = req_valid[i] & phase_en[i]. req_ready is combinational from eligibility, lock state and the pointer; it never asserts for an ineligible requester.
- At most one req_ready bit per cycle. mem_en = |(req_valid & req_ready); mem_we/addr/wdata are muxed combinationally from the winner.
- Round-robin pointer ptr (reset 0): search starts at ptr; after a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- FSM arb_state_t:
  - ARB: normal arbitration.
  - LOCKED: owner register holds the granted requester.
    - ARB -> LOCKED when the granted access has req_lock[i]=1; owner <= i.
    - In LOCKED, only owner can be granted, and only if eligible; the others see ready=0.
    - LOCKED -> ARB on a granted owner access with req_lock=0, or when phase_en[owner] drops (lock forcibly released that cycle, no grant).
    - ptr is not updated while LOCKED; on release ptr <= owner+1.
- Response pipe: READ_LAT-deep shift of {valid, id}. A read grant enters {1,i}.
  - rsp_valid[id] = 1 exactly READ_LAT cycles after the grant cycle; rsp_data = mem_rdata in that cycle.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses, in order.
- Ordering: accesses reach memory in grant order, so a read granted after a write to the same address returns the new data. No extra hazard logic.
- phase_en dropping mid-flight does not cancel reads already granted; their responses are still delivered.
- idle = !mem_en & pipe empty; the controller uses it to switch phases safely.
- Reset: ptr=0, state=ARB, owner=0, pipe cleared. All outputs 0 in the reset cycle and the cycle after, except idle=1. In-flight reads are discarded and no rsp_valid is issued.
- Throughput: 1 access/cycle; grant latency 0 cycles with a single eligible requester.

Optional Feature:
- GRID_ARB_STATS_EN defined: adds outputs stat_grants[NUM_REQ*32] and stat_stalls[NUM_REQ*32].
  - Grant counters increment on valid&ready.
  - Stall counters increment on eligible & !ready.
  - Both saturate at 2^32-1, clear on rst, and clear on a stat_clr input pulse (added port).
- Undefined: no counters, no stat ports; behaviour is otherwise identical.

Decomposition:
- In defs: arb_state_t {ARB, LOCKED}, GRID_ADDR_W, GRID_DATA_W, requester id localparams REQ_SCATTER=0, REQ_SOLVE=1, REQ_GATHER=2.
- One sub-module arb_rsp_pipe (READ_LAT-deep valid/id shift register with an empty flag); the top keeps FSM, pointer and mux.

Test Plan:
- All three eligible reads every cycle for 9 cycles, ptr=0 -> grants 0,1,2,0,1,2,0,1,2; each rsp_valid 2 cycles after its grant, with data matching a memory model.
- Scatter RMW: read addr 0x010 with lock=1, then write 0x010 with lock=0, while gather requests continuously -> gather gets no grant between the two; then gather is granted next.
- phase_en=3'b100 with all three requesting -> only gather is granted; scatter/solver stall, ready=0.
- Lock held by solver, phase_en[1] drops -> LOCKED->ARB that cycle with no grant; next cycle the scatter (ptr=2 wraps) / gather order is correct.
- Write 0xDEADBEEF to 0x020, then read 0x020 in the next cycle -> rsp_data=0xDEADBEEF.
- rst asserted 1 cycle after a read grant -> no rsp_valid afterwards, idle=1, next grant starts from requester 0.
